uart_tx_fifo: RTL and testbench

Transmit buffer directly upstream of the UART core: the CPU pushes bytes at its own rate, and this block drains them one frame at a time into the UART transmitter. It drives UART_WRITE and DATA_IN_Tx. It paces itself on UART_AVAIL and IRQ_Tx. It reports fill level, overflow and an end-of-burst interrupt to the CPU.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_fifo.sv | 84 ++++++++
 rtl/uart_tx_fifo.sv | 108 ++++++++++
 tb/tb_uart_tx_fifo.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit buffer.
//   BYTE_W     : width of one UART data byte
//   DEPTH_DEF  : default FIFO depth (entries, power of two)
//   AW_DEF     : default pointer width, log2(DEPTH_DEF)
//   tx_state_e : drain FSM states (2-bit encoding)
package uart_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned AW_DEF    = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous byte FIFO with registered level / full / empty.
//   clk, rst     : clock, asynchronous active-high reset
//   i_push       : write request, i_push_data stored when accepted
//   i_pop        : read request, o_pop_data is the current head
//   i_flush      : clears pointers and level; beats same-cycle push/pop
//   o_full       : level == DEPTH
//   o_empty      : level == 0
//   o_level      : stored entries, 0..DEPTH
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [BYTE_W-1:0] o_pop_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_level
);

  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              r_full;
  logic              r_empty;
  logic [AW:0]       w_level_nxt;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign w_pop_ok  = i_pop & ~r_empty & ~i_flush;
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign w_push_ok = i_push & ~i_flush & (~r_full | w_pop_ok);

  always_comb begin
    w_level_nxt = r_level;
    if (i_flush) begin
      w_level_nxt = '0;
    end else if (w_push_ok && !w_pop_ok) begin
      w_level_nxt = r_level + 1'b1;
    end else if (!w_push_ok && w_pop_ok) begin
      w_level_nxt = r_level - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LP_FULL);
      r_empty <= (w_level_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_level    = r_level;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of the UART core. The CPU pushes bytes; this block
// drains them one frame at a time using UART_WRITE / DATA_IN_Tx, paced by
// UART_AVAIL (sampled in IDLE) and IRQ_Tx (frame finished).
//   clk_CPU, RST : clock, asynchronous active-high reset
//   EN           : drain enable (pushes accepted regardless)
//   wr_en/wr_data: CPU push
//   flush        : clear stored bytes (current frame still completes)
//   clr_ovf      : clear sticky overflow
//   UART_AVAIL   : UART transmitter idle
//   IRQ_Tx       : UART frame-done pulse
//   UART_WRITE   : one-cycle start-frame pulse
//   DATA_IN_Tx   : byte being transmitted (held for the whole frame)
//   full/empty/level : FIFO status
//   overflow     : sticky, push dropped while full
//   irq_empty    : one-cycle pulse, last frame done with FIFO empty
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic              clk_CPU,
  input  logic              RST,
  input  logic              EN,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              flush,
  input  logic              clr_ovf,
  input  logic              UART_AVAIL,
  input  logic              IRQ_Tx,
  output logic              UART_WRITE,
  output logic [BYTE_W-1:0] DATA_IN_Tx,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level,
  output logic              overflow,
  output logic              irq_empty
);

  tx_state_e         r_state;
  logic [BYTE_W-1:0] w_head;
  logic              w_start;
  logic              w_push_acc;
  logic              w_ovf_set;

  // A flush in the same cycle discards the head, so no frame starts from it.
  assign w_start    = (r_state == ST_IDLE) & EN & ~empty & UART_AVAIL & ~flush;
  assign w_push_acc = wr_en & ~flush & (~full | w_start);
  assign w_ovf_set  = wr_en & ~flush & full & ~w_start;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk         (clk_CPU),
    .rst         (RST),
    .i_push      (wr_en),
    .i_push_data (wr_data),
    .i_pop       (w_start),
    .i_flush     (flush),
    .o_pop_data  (w_head),
    .o_full      (full),
    .o_empty     (empty),
    .o_level     (level)
  );

  always_ff @(posedge clk_CPU or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      UART_WRITE <= 1'b0;
      DATA_IN_Tx <= '0;
      irq_empty  <= 1'b0;
    end else begin
      UART_WRITE <= 1'b0;
      irq_empty  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            DATA_IN_Tx <= w_head;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          UART_WRITE <= 1'b1;
          r_state    <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (IRQ_Tx) begin
            r_state   <= ST_IDLE;
            irq_empty <= empty & ~w_push_acc;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_CPU or posedge RST) begin
    if (RST) begin
      overflow <= 1'b0;
    end else if (w_ovf_set) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo.
module tb_uart_tx_fifo;

  logic       clk_CPU;
  logic       RST;
  logic       EN;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       clr_ovf;
  logic       UART_AVAIL;
  logic       IRQ_Tx;
  logic       UART_WRITE;
  logic [7:0] DATA_IN_Tx;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       irq_empty;

  int n_cmp;
  int n_err;

  uart_tx_fifo #(
    .DEPTH (16),
    .AW    (4)
  ) dut (
    .clk_CPU    (clk_CPU),
    .RST        (RST),
    .EN         (EN),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .flush      (flush),
    .clr_ovf    (clr_ovf),
    .UART_AVAIL (UART_AVAIL),
    .IRQ_Tx     (IRQ_Tx),
    .UART_WRITE (UART_WRITE),
    .DATA_IN_Tx (DATA_IN_Tx),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .irq_empty  (irq_empty)
  );

  initial clk_CPU = 1'b0;
  always #5 clk_CPU = ~clk_CPU;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_CPU);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_uw"},   32'(UART_WRITE), 32'd0);
    chk({tag, "_data"}, 32'(DATA_IN_Tx), 32'h00);
    chk({tag, "_full"}, 32'(full),       32'd0);
    chk({tag, "_empty"},32'(empty),      32'd1);
    chk({tag, "_lvl"},  32'(level),      32'd0);
    chk({tag, "_ovf"},  32'(overflow),   32'd0);
    chk({tag, "_irqe"}, 32'(irq_empty),  32'd0);
  endtask

  initial begin
    logic [7:0] exp_b;
    n_cmp = 0;
    n_err = 0;
    RST = 1'b1; EN = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
    clr_ovf = 1'b0; UART_AVAIL = 1'b0; IRQ_Tx = 1'b0;

    // ---- reset ----
    tick(); tick();
    chk_reset_vals("rst");
    RST = 1'b0;
    EN = 1'b1; UART_AVAIL = 1'b1;

    // ---- single byte 5A ----
    wr_en = 1'b1; wr_data = 8'h5A;
    tick();                                    // edge N: push
    wr_en = 1'b0;
    chk("t1_lvl_after_push", 32'(level), 32'd1);
    chk("t1_empty_after_push", 32'(empty), 32'd0);
    chk("t1_uw_n", 32'(UART_WRITE), 32'd0);
    tick();                                    // N+1: pop
    chk("t1_data_pop", 32'(DATA_IN_Tx), 32'h5A);
    chk("t1_lvl_pop", 32'(level), 32'd0);
    chk("t1_uw_n1", 32'(UART_WRITE), 32'd0);
    tick();                                    // N+2
    chk("t1_uw_n2", 32'(UART_WRITE), 32'd1);
    tick();                                    // N+3
    chk("t1_uw_n3", 32'(UART_WRITE), 32'd0);
    chk("t1_data_hold", 32'(DATA_IN_Tx), 32'h5A);
    IRQ_Tx = 1'b1;
    tick();
    IRQ_Tx = 1'b0;
    chk("t1_irq_empty", 32'(irq_empty), 32'd1);
    tick();
    chk("t1_irq_empty_off", 32'(irq_empty), 32'd0);

    // ---- four bytes 01..04 ----
    UART_AVAIL = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    chk("t2_lvl4", 32'(level), 32'd4);
    chk("t2_uw_blocked", 32'(UART_WRITE), 32'd0);
    UART_AVAIL = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();                                  // pop edge
      chk("t2_data", 32'(DATA_IN_Tx), 32'(i));
      chk("t2_lvl", 32'(level), 32'(4 - i));
      chk("t2_uw_pop", 32'(UART_WRITE), 32'd0);
      tick();
      chk("t2_uw_hi", 32'(UART_WRITE), 32'd1);
      tick();
      chk("t2_uw_lo", 32'(UART_WRITE), 32'd0);
      IRQ_Tx = 1'b1;
      tick();
      IRQ_Tx = 1'b0;
      chk("t2_irqe", 32'(irq_empty), (i == 4) ? 32'd1 : 32'd0);
    end
    tick();
    chk("t2_uw_end", 32'(UART_WRITE), 32'd0);
    chk("t2_lvl_end", 32'(level), 32'd0);

    // ---- overflow ----
    UART_AVAIL = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      tick();
    end
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_lvl16", 32'(level), 32'd16);
    chk("t3_ovf_pre", 32'(overflow), 32'd0);
    wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    chk("t3_ovf_set", 32'(overflow), 32'd1);
    chk("t3_lvl_drop", 32'(level), 32'd16);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 32'd0);
    wr_en = 1'b1; wr_data = 8'hFF; clr_ovf = 1'b1;
    tick();
    wr_en = 1'b0; clr_ovf = 1'b0;
    chk("t3_ovf_set_wins", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_ovf_clr2", 32'(overflow), 32'd0);
    wr_en = 1'b1; wr_data = 8'hEE; UART_AVAIL = 1'b1;
    tick();                                    // push + pop while full
    wr_en = 1'b0;
    chk("t3_pp_lvl", 32'(level), 32'd16);
    chk("t3_pp_ovf", 32'(overflow), 32'd0);
    chk("t3_pp_data", 32'(DATA_IN_Tx), 32'h10);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("t3_uw_hi", 32'(UART_WRITE), 32'd1);
      tick();
      chk("t3_uw_lo", 32'(UART_WRITE), 32'd0);
      IRQ_Tx = 1'b1;
      tick();
      IRQ_Tx = 1'b0;
      chk("t3_irqe_mid", 32'(irq_empty), 32'd0);
      tick();
      exp_b = (k == 16) ? 8'hEE : 8'(8'h10 + k);
      chk("t3_drain_data", 32'(DATA_IN_Tx), 32'(exp_b));
      chk("t3_drain_lvl", 32'(level), 32'(16 - k));
    end
    tick();
    chk("t3_last_uw", 32'(UART_WRITE), 32'd1);
    tick();
    IRQ_Tx = 1'b1;
    tick();
    IRQ_Tx = 1'b0;
    chk("t3_irqe_end", 32'(irq_empty), 32'd1);
    tick();
    chk("t3_idle_uw", 32'(UART_WRITE), 32'd0);
    chk("t3_idle_data", 32'(DATA_IN_Tx), 32'hEE);

    // ---- flush mid-burst ----
    UART_AVAIL = 1'b0;
    wr_en = 1'b1; wr_data = 8'hA1; tick();
    wr_data = 8'hA2; tick();
    wr_data = 8'hA3; tick();
    wr_en = 1'b0;
    chk("t4_lvl3", 32'(level), 32'd3);
    UART_AVAIL = 1'b1;
    tick();
    chk("t4_data", 32'(DATA_IN_Tx), 32'hA1);
    chk("t4_lvl2", 32'(level), 32'd2);
    tick();
    chk("t4_uw_hi", 32'(UART_WRITE), 32'd1);
    tick();
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'hBB;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    chk("t4_flush_lvl", 32'(level), 32'd0);
    chk("t4_flush_empty", 32'(empty), 32'd1);
    chk("t4_flush_ovf", 32'(overflow), 32'd0);
    tick(); tick();
    chk("t4_data_hold", 32'(DATA_IN_Tx), 32'hA1);
    chk("t4_uw_quiet", 32'(UART_WRITE), 32'd0);
    IRQ_Tx = 1'b1;
    tick();
    IRQ_Tx = 1'b0;
    chk("t4_irqe", 32'(irq_empty), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_write", 32'(UART_WRITE), 32'd0);
    end
    chk("t4_data_end", 32'(DATA_IN_Tx), 32'hA1);

    // ---- EN gating, then reset mid-frame ----
    EN = 1'b0;
    wr_en = 1'b1; wr_data = 8'hC1; tick();
    wr_data = 8'hC2; tick();
    wr_data = 8'hC3; tick();
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_en_off_uw", 32'(UART_WRITE), 32'd0);
      chk("t5_en_off_lvl", 32'(level), 32'd3);
    end
    EN = 1'b1;
    tick();
    chk("t5_resume_data", 32'(DATA_IN_Tx), 32'hC1);
    chk("t5_resume_lvl", 32'(level), 32'd2);
    tick();
    chk("t5_uw_hi", 32'(UART_WRITE), 32'd1);
    tick();
    #1;
    RST = 1'b1;
    #1;
    chk_reset_vals("t6_async");
    tick();
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      IRQ_Tx = 1'b1;
      tick();
      IRQ_Tx = 1'b0;
      chk("t6_irqe_ignored", 32'(irq_empty), 32'd0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_write", 32'(UART_WRITE), 32'd0);
    end
    chk_reset_vals("t6_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
